// File: rtl/dlatch_write_sched_pkg.sv
// Shared types and constants for the D-latch write scheduler.
// Holds the FSM state enum, a clog2 helper and the default timing.
package dlatch_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_ACK   = 3'd4
    } state_e;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_NUM_LAT   = 4;
    localparam int DEF_WIDTH     = 1;
    localparam int DEF_AW        = 2;
    localparam int DEF_SETUP_CYC = 1;
    localparam int DEF_PULSE_CYC = 2;
    localparam int DEF_HOLD_CYC  = 1;

    // Smallest r with 2**r >= v (0 for v <= 1).
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) begin
            m = b;
        end
        if (c > m) begin
            m = c;
        end
        return m;
    endfunction

endpackage

// File: rtl/dlatch_write_sched_if.sv
// Requester-side bus of the latch write scheduler.
// master: requesters (req/wdata/waddr out); slave: scheduler.
interface dlatch_write_sched_if
    import dlatch_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int AW      = DEF_AW
) ();

    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] wdata;
    logic [NUM_REQ*AW-1:0]    waddr;
    logic [NUM_REQ-1:0]       gnt;
    logic [NUM_REQ-1:0]       done;
    logic                     err;
    logic                     busy;

    modport master (
        output req, wdata, waddr,
        input  gnt, done, err, busy
    );

    modport slave (
        input  req, wdata, waddr,
        output gnt, done, err, busy
    );

endinterface

// File: rtl/dlatch_write_sched_rr_arbiter.sv
// Combinational round-robin pick: first req at or after ptr, wrapping.
// Ports: req, ptr in; one-hot gnt and its index idx out.
module rr_arbiter
    import dlatch_sched_pkg::*;
#(
    parameter int N  = DEF_NUM_REQ,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx
);

    logic found;
    int   j;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = PW'(j);
            end
        end
    end

endmodule

// File: rtl/dlatch_write_sched.sv
// Shares one write port into a bank of D latches among requesters.
// Ports: clk, rst_n (sync, active low); bus (requester side, slave);
// lat_d shared D, lat_en one En per word, lat_q readback from the bank.
module dlatch_write_sched
    import dlatch_sched_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int NUM_LAT   = DEF_NUM_LAT,
    parameter int WIDTH     = DEF_WIDTH,
    parameter int AW        = DEF_AW,
    parameter int SETUP_CYC = DEF_SETUP_CYC,
    parameter int PULSE_CYC = DEF_PULSE_CYC,
    parameter int HOLD_CYC  = DEF_HOLD_CYC
) (
    input  logic                     clk,
    input  logic                     rst_n,
    dlatch_write_sched_if.slave      bus,
    output logic [WIDTH-1:0]         lat_d,
    output logic [NUM_LAT-1:0]       lat_en,
    input  logic [NUM_LAT*WIDTH-1:0] lat_q
);

    localparam int PW   = (clog2(NUM_REQ) < 1) ? 1 : clog2(NUM_REQ);
    localparam int MAXC = max3(SETUP_CYC, PULSE_CYC, HOLD_CYC);
    localparam int TW   = (clog2(MAXC + 1) < 1) ? 1 : clog2(MAXC + 1);

    localparam logic [TW-1:0] SETUP_LD = TW'(SETUP_CYC - 1);
    localparam logic [TW-1:0] PULSE_LD = TW'(PULSE_CYC - 1);
    localparam logic [TW-1:0] HOLD_LD  = TW'(HOLD_CYC - 1);

    state_e               state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [PW-1:0]        idx_q, idx_d;
    logic [AW-1:0]        addr_q, addr_d;
    logic [WIDTH-1:0]     data_q, data_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic                 err_q, err_d;
    logic                 busy_q, busy_d;
    logic [WIDTH-1:0]     d_q, d_d;
    logic [NUM_LAT-1:0]   en_q, en_d;

    logic [NUM_REQ-1:0]   arb_gnt;
    logic [PW-1:0]        arb_idx;
    logic [AW-1:0]        sel_addr;
    logic [WIDTH-1:0]     sel_data;
    logic [NUM_LAT-1:0]   dec_en;
    logic [WIDTH-1:0]     q_sel;
    logic                 addr_ok;
    logic [PW-1:0]        ptr_next;

    rr_arbiter #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_arb (
        .req (bus.req),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    // Slice out the winner's address and data.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) begin
                sel_addr = bus.waddr[i*AW +: AW];
                sel_data = bus.wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    // Address decode for En and readback; out-of-range hits nothing.
    always_comb begin
        dec_en  = '0;
        q_sel   = '0;
        addr_ok = (int'(addr_q) < NUM_LAT);
        for (int w = 0; w < NUM_LAT; w++) begin
            if (int'(addr_q) == w) begin
                dec_en[w] = 1'b1;
                q_sel     = lat_q[w*WIDTH +: WIDTH];
            end
        end
    end

    assign ptr_next = (int'(idx_q) == NUM_REQ - 1) ? '0 : idx_q + 1'b1;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        data_d  = data_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        err_d   = 1'b0;
        busy_d  = busy_q;
        d_d     = d_q;
        en_d    = en_q;
        unique case (state_q)
            ST_IDLE: begin
                if (|bus.req) begin
                    state_d = ST_SETUP;
                    idx_d   = arb_idx;
                    addr_d  = sel_addr;
                    data_d  = sel_data;
                    gnt_d   = arb_gnt;
                    d_d     = sel_data;
                    timer_d = SETUP_LD;
                    busy_d  = 1'b1;
                end
            end
            ST_SETUP: begin
                if (timer_q == '0) begin
                    state_d = ST_PULSE;
                    timer_d = PULSE_LD;
                    en_d    = dec_en;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_PULSE: begin
                if (timer_q == '0) begin
                    state_d = ST_HOLD;
                    timer_d = HOLD_LD;
                    en_d    = '0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_HOLD: begin
                if (timer_q == '0) begin
                    // Latch has been closed for HOLD_CYC; Q is stable.
                    state_d = ST_ACK;
                    done_d  = gnt_q;
                    err_d   = !addr_ok || (q_sel != data_q);
                    ptr_d   = ptr_next;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            ptr_q   <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            d_q     <= '0;
            en_q    <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            d_q     <= d_d;
            en_q    <= en_d;
        end
    end

    assign bus.gnt  = gnt_q;
    assign bus.done = done_q;
    assign bus.err  = err_q;
    assign bus.busy = busy_q;
    assign lat_d    = d_q;
    assign lat_en   = en_q;

endmodule

// File: tb/tb_dlatch_write_sched.sv
// Self-checking bench for dlatch_write_sched.
// Two instances: default bank (4 words) and a 3-word bank.
module tb_dlatch_write_sched;
    import dlatch_sched_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dlatch_write_sched_if #(.NUM_REQ(4), .WIDTH(1), .AW(2)) bus_a ();
    dlatch_write_sched_if #(.NUM_REQ(4), .WIDTH(1), .AW(2)) bus_b ();

    logic [0:0] lat_d_a, lat_d_b;
    logic [3:0] lat_en_a, bank_a, lat_q_a;
    logic [2:0] lat_en_b, bank_b, lat_q_b;
    logic       stuck = 1'b0;

    always @(lat_en_a or lat_d_a) begin
        for (int i = 0; i < 4; i++) begin
            if (lat_en_a[i]) bank_a[i] = lat_d_a[0];
        end
    end

    always @(lat_en_b or lat_d_b) begin
        for (int i = 0; i < 3; i++) begin
            if (lat_en_b[i]) bank_b[i] = lat_d_b[0];
        end
    end

    assign lat_q_a = stuck ? 4'b0000 : bank_a;
    assign lat_q_b = bank_b;

    dlatch_write_sched #(
        .NUM_REQ(4), .NUM_LAT(4), .WIDTH(1), .AW(2),
        .SETUP_CYC(1), .PULSE_CYC(2), .HOLD_CYC(1)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a),
        .lat_d(lat_d_a), .lat_en(lat_en_a), .lat_q(lat_q_a)
    );

    dlatch_write_sched #(
        .NUM_REQ(4), .NUM_LAT(3), .WIDTH(1), .AW(2),
        .SETUP_CYC(1), .PULSE_CYC(2), .HOLD_CYC(1)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b),
        .lat_d(lat_d_b), .lat_en(lat_en_b), .lat_q(lat_q_b)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus_a.req = '0;
        bus_b.req = '0;
        stuck = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Samples from the current cycle until a done pulse (bounded).
    task automatic run(input bit sel, output int en_cnt, output int g_cnt,
                       output logic [3:0] done_v, output logic err_v,
                       output bit seen);
        logic [3:0] g, d, e;
        en_cnt = 0;
        g_cnt = 0;
        done_v = '0;
        err_v = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            g = sel ? bus_b.gnt : bus_a.gnt;
            d = sel ? bus_b.done : bus_a.done;
            e = sel ? {1'b0, lat_en_b} : lat_en_a;
            if (g != 0) g_cnt++;
            if (e != 0) en_cnt++;
            if (d != 0) begin
                seen = 1'b1;
                done_v = d;
                err_v = sel ? bus_b.err : bus_a.err;
                break;
            end
            tick();
        end
    endtask

    function automatic int outs_a();
        return 32'({bus_a.gnt, bus_a.done, bus_a.err, bus_a.busy,
                    lat_en_a, lat_d_a});
    endfunction

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic [3:0] done;
        logic       err;
        logic       busy;
        logic [3:0] en;
        logic       d;
    } vec_t;

    vec_t tbl[7];
    logic [3:0] rr_exp[6];

    initial begin
        int en_cnt, g_cnt, ng, idle;
        logic [3:0] dv, prev;
        logic ev;
        bit seen;
        logic [3:0] order[6];
        int gaps[6];

        tbl[0] = '{4'b0100, 4'b0100, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b1};
        tbl[1] = '{4'b0000, 4'b0100, 4'b0000, 1'b0, 1'b1, 4'b1000, 1'b1};
        tbl[2] = '{4'b0000, 4'b0100, 4'b0000, 1'b0, 1'b1, 4'b1000, 1'b1};
        tbl[3] = '{4'b0000, 4'b0100, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b1};
        tbl[4] = '{4'b0000, 4'b0100, 4'b0100, 1'b0, 1'b1, 4'b0000, 1'b1};
        tbl[5] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1};
        tbl[6] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1};
        rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b1000;
        rr_exp[3] = 4'b0001; rr_exp[4] = 4'b0010; rr_exp[5] = 4'b1000;

        bus_a.req = '0;
        bus_a.waddr = {2'd3, 2'd2, 2'd1, 2'd0};
        bus_a.wdata = 4'b1111;
        bus_b.req = '0;
        bus_b.waddr = {2'd0, 2'd0, 2'd0, 2'd3};
        bus_b.wdata = 4'b0001;
        @(negedge clk);

        // Reset held with all requests pending.
        rst_n = 1'b0;
        bus_a.req = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("reset_outs_%0d", k), outs_a(), 0);
        end
        rst_n = 1'b1;
        chk("release_idle_outs", outs_a(), 0);
        tick();
        chk("release_first_gnt", 32'(bus_a.gnt), 1);
        bus_a.req = '0;
        run(1'b0, en_cnt, g_cnt, dv, ev, seen);
        chk("release_txn_done", 32'(seen), 1);
        tick();

        // Single write, req 2 -> word 3, data 1.
        do_reset();
        bus_a.waddr = {2'd0, 2'd3, 2'd1, 2'd0};
        bus_a.wdata = 4'b0100;
        for (int k = 0; k < 7; k++) begin
            bus_a.req = tbl[k].req;
            tick();
            chk($sformatf("single_vec_%0d", k), outs_a(),
                32'({tbl[k].gnt, tbl[k].done, tbl[k].err, tbl[k].busy,
                     tbl[k].en, tbl[k].d}));
        end
        chk("single_bank_word3", 32'(bank_a[3]), 1);

        // Round robin with req 1011 held.
        do_reset();
        bus_a.waddr = {2'd3, 2'd2, 2'd1, 2'd0};
        bus_a.wdata = 4'b1010;
        bus_a.req = 4'b1011;
        ng = 0;
        idle = 0;
        prev = '0;
        for (int c = 0; c < 60 && ng < 6; c++) begin
            tick();
            if (bus_a.gnt != 0 && prev == 0) begin
                order[ng] = bus_a.gnt;
                gaps[ng] = idle;
                ng++;
            end
            if (bus_a.gnt == 0) idle++;
            else idle = 0;
            if (bus_a.done != 0)
                chk($sformatf("rr_err_%0d", ng), 32'(bus_a.err), 0);
            prev = bus_a.gnt;
        end
        chk("rr_grant_count", ng, 6);
        for (int k = 0; k < ng; k++) begin
            chk($sformatf("rr_order_%0d", k), 32'(order[k]), 32'(rr_exp[k]));
            if (k > 0) chk($sformatf("rr_gap_%0d", k), gaps[k], 1);
        end
        bus_a.req = '0;
        for (int c = 0; c < 10 && bus_a.busy; c++) tick();
        chk("rr_drain_busy", 32'(bus_a.busy), 0);

        // Readback mismatch: lat_q forced to 0, write 1 to word 1.
        do_reset();
        stuck = 1'b1;
        bus_a.waddr = {2'd3, 2'd2, 2'd1, 2'd0};
        bus_a.wdata = 4'b0010;
        bus_a.req = 4'b0010;
        tick();
        bus_a.req = '0;
        run(1'b0, en_cnt, g_cnt, dv, ev, seen);
        chk("mm_done_seen", 32'(seen), 1);
        chk("mm_done", 32'(dv), 2);
        chk("mm_err", 32'(ev), 1);
        chk("mm_en_cycles", en_cnt, 2);
        chk("mm_gnt_span", g_cnt, 5);
        tick();
        stuck = 1'b0;

        // Out-of-range address on the 3-word bank.
        do_reset();
        bus_b.req = 4'b0001;
        tick();
        bus_b.req = '0;
        run(1'b1, en_cnt, g_cnt, dv, ev, seen);
        chk("bad_done_seen", 32'(seen), 1);
        chk("bad_done", 32'(dv), 1);
        chk("bad_err", 32'(ev), 1);
        chk("bad_en_cycles", en_cnt, 0);
        chk("bad_gnt_span", g_cnt, 5);
        tick();
        chk("bad_idle_busy", 32'(bus_b.busy), 0);

        // Reset in the second PULSE cycle.
        do_reset();
        bus_a.waddr = {2'd2, 2'd0, 2'd1, 2'd0};
        bus_a.wdata = 4'b1000;
        bus_a.req = 4'b0100;
        tick();
        bus_a.req = '0;
        run(1'b0, en_cnt, g_cnt, dv, ev, seen);
        chk("mid_pre_done", 32'(dv), 4);
        tick();
        bus_a.req = 4'b1000;
        tick();
        chk("mid_setup_gnt", 32'(bus_a.gnt), 8);
        tick();
        chk("mid_pulse1_en", 32'(lat_en_a), 4);
        tick();
        chk("mid_pulse2_en", 32'(lat_en_a), 4);
        rst_n = 1'b0;
        bus_a.req = 4'b1010;
        tick();
        chk("mid_rst_outs", outs_a(), 0);
        rst_n = 1'b1;
        tick();
        chk("mid_regrant", 32'(bus_a.gnt), 2);
        chk("mid_no_done", 32'(bus_a.done), 0);
        bus_a.req = '0;
        run(1'b0, en_cnt, g_cnt, dv, ev, seen);
        chk("mid_done_owner", 32'(dv), 2);
        chk("mid_err", 32'(ev), 0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dlatch_write_sched.md
Name: dlatch_write_sched

Overview:
Controller that shares one write port into a bank of level-sensitive D latches (DLatch instances, ports Q, QN, D, En) between several requesters. It arbitrates round-robin, then sequences each write as a timed protocol: data setup with En low, an En pulse, and a hold window with En low again. In the done cycle it reads back Q to confirm capture. It sits between the requesting logic and the latch bank and is the only driver of every latch D and En in the bank.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
NUM_LAT, 4, number of latch words in the bank (>=1)
WIDTH, 1, data bits per latch word
AW, 2, address width, must satisfy 2**AW >= NUM_LAT
SETUP_CYC, 1, cycles D is stable before En rises (>=1)
PULSE_CYC, 2, cycles En is high (>=1)
HOLD_CYC, 1, cycles D is held after En falls (>=1)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk
req  in  NUM_REQ  write request per requester, level
wdata  in  NUM_REQ*WIDTH  write data; slice i belongs to requester i
waddr  in  NUM_REQ*AW  target latch word; slice i belongs to requester i
gnt  out  NUM_REQ  one-hot, current owner of the write port
done  out  NUM_REQ  one-cycle completion pulse to the owner
err  out  1  one-cycle pulse with done: bad address or readback mismatch
busy  out  1  high in every state except IDLE
lat_d  out  WIDTH  shared D bus to all latch words
lat_en  out  NUM_LAT  En per latch word, at most one bit high
lat_q  in  NUM_LAT*WIDTH  Q readback from the bank

Behaviour:
- Reset (rst_n=0 at a clock edge): state=IDLE, gnt=0, done=0, err=0, busy=0, lat_en=0, lat_d=0, round-robin pointer=0, timer=0. A reset during any phase forces lat_en low at that edge. The interrupted write is abandoned and no done is issued.
- All outputs are registered.
- State machine: IDLE -> SETUP -> PULSE -> HOLD -> ACK -> IDLE.
- IDLE, with at least one req bit high at the edge:
  - pick the first requester at or after the pointer, searching in increasing index and wrapping;
  - latch its wdata and waddr into internal registers;
  - set gnt[i] and lat_d to the latched data;
  - load timer=SETUP_CYC-1 and move to SETUP.
- SETUP: lat_en=0. When timer reaches 0, load timer=PULSE_CYC-1 and move to PULSE. The En bit rises on that same edge.
- PULSE: lat_en[addr]=1. When timer reaches 0, load timer=HOLD_CYC-1 and move to HOLD. En falls on that edge.
- HOLD: lat_en=0 and lat_d unchanged. When timer reaches 0, move to ACK.
- ACK, exactly one cycle:
  - done[i]=1 and gnt[i] stays high;
  - err=1 if addr>=NUM_LAT or the lat_q slice for addr differs from the latched data;
  - pointer is set to (i+1) mod NUM_REQ;
  - next state is IDLE, where gnt is cleared.
- Cycle counts: SETUP lasts SETUP_CYC cycles, PULSE lasts PULSE_CYC, HOLD lasts HOLD_CYC. The first cycle with gnt high to the done cycle spans SETUP_CYC+PULSE_CYC+HOLD_CYC+1 cycles.
- Arbitration spacing: there is at least one IDLE cycle between transactions. A req seen during ACK is arbitrated in the following IDLE cycle.
- Out-of-range address (addr>=NUM_LAT): the full timing sequence still runs, but no lat_en bit is ever asserted, and err pulses in ACK.
- A requester dropping req after grant has no effect; the write completes with the data latched at grant. A requester holding req through done is eligible again only after the others in round-robin order.
- lat_d keeps the last written value in IDLE, so there are no needless D toggles.
- lat_en is never high outside PULSE. lat_d never changes while any lat_en bit is high.
- Timer width is clog2 of max(SETUP_CYC,PULSE_CYC,HOLD_CYC)+1.

Decomposition:
- Shared package dlatch_sched_pkg holds:
  - the state enum (IDLE, SETUP, PULSE, HOLD, ACK);
  - a clog2 helper function;
  - the default timing constants.
- One natural sub-module, rr_arbiter: combinational round-robin pick from req and pointer, giving a one-hot grant and an index. The FSM, timer and readback check stay in the top module.

Test Plan:
- Reset: hold rst_n=0 three cycles with req=4'b1111, then release. Every output is 0 while rst_n is low, and on the first IDLE cycle after release. Requester 0 receives gnt=4'b0001.
- Single write with defaults: req[2]=1, waddr[2]=3, wdata[2]=1, behavioural DLatch bank connected.
  - lat_en[3] is high for exactly 2 cycles, preceded by 1 SETUP cycle and followed by 1 HOLD cycle.
  - done[2] pulses 5 cycles after gnt[2] rises; err=0.
- Round-robin: req=4'b1011 held continuously. Grant order is 0,1,3,0,1,3 with one IDLE cycle between transactions and no grant to requester 2.
- Readback mismatch: model lat_q stuck at 0 and write data 1 to address 1. err=1 in the same cycle as done; lat_en[1] pulse is still 2 cycles.
- Bad address with NUM_LAT=3: write to addr 3. lat_en stays 0 for the whole transaction, and done and err pulse together.
- Reset mid-PULSE: drop rst_n in the second PULSE cycle.
  - lat_en goes 0 at that edge and no done is issued.
  - After release, a pending req on requester 1 is granted, with the pointer back at 0.
